// File: rtl/sram_async_ctrl.sv
// Asynchronous-SRAM controller: registered request/busy handshake, wait states, byte lanes, read turnaround.
// Optional SRAM_RDATA_REG_EN adds an input register on pins_din and one extra read ACCESS cycle.
module sram_async_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1,
  parameter int TURNAROUND  = 1,
  localparam int LANES      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LANES-1:0]  be,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [ADDR_W-1:0] ram_adr,
  output logic              ram_cs_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic [LANES-1:0]  ram_be_n,
  output logic [DATA_W-1:0] pins_dout,
  input  logic [DATA_W-1:0] pins_din,
  output logic              pins_drive
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, TURN} state_t;

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);
  localparam logic [1:0] TURN_LOAD = 2'((TURNAROUND > 0) ? (TURNAROUND - 1) : 0);

  state_t      state;
  logic        we_q;
  logic [2:0]  wcnt;
  logic [1:0]  tcnt;
  logic        extra;
  logic [DATA_W-1:0] capture;

`ifdef SRAM_RDATA_REG_EN
  localparam logic RD_EXTRA = 1'b1;
  logic [DATA_W-1:0] din_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) din_q <= '0;
    else          din_q <= pins_din;
  end

  always_comb capture = din_q;
`else
  localparam logic RD_EXTRA = 1'b0;

  always_comb capture = pins_din;
`endif

  // Outputs are loaded with the values of the state being entered, so every strobe is a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      rvalid     <= 1'b0;
      rdata      <= '0;
      ram_adr    <= '0;
      pins_dout  <= '0;
      ram_cs_n   <= 1'b1;
      ram_oe_n   <= 1'b1;
      ram_we_n   <= 1'b1;
      ram_be_n   <= '1;
      pins_drive <= 1'b0;
      we_q       <= 1'b0;
      wcnt       <= '0;
      tcnt       <= '0;
      extra      <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (req && !busy) begin
            state    <= SETUP;
            busy     <= 1'b1;
            we_q     <= we;
            ram_adr  <= addr;
            ram_cs_n <= 1'b0;
            wcnt     <= WAIT_LOAD;
            extra    <= RD_EXTRA & ~we;
            if (we) begin
              pins_dout  <= wdata;
              ram_be_n   <= ~be;
              pins_drive <= 1'b1;
            end else begin
              ram_oe_n <= 1'b0;
              ram_be_n <= '0;
            end
          end
        end
        SETUP: begin
          state <= ACCESS;
          if (we_q) ram_we_n <= 1'b0;
        end
        ACCESS: begin
          if (wcnt != 3'd0) begin
            wcnt <= wcnt - 3'd1;
          end else if (extra) begin
            extra <= 1'b0;
          end else if (we_q) begin
            state    <= HOLD;
            ram_we_n <= 1'b1;
          end else begin
            rdata    <= capture;
            rvalid   <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_cs_n <= 1'b1;
            ram_be_n <= '1;
            if (TURNAROUND == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= TURN;
              tcnt  <= TURN_LOAD;
            end
          end
        end
        HOLD: begin
          state      <= IDLE;
          busy       <= 1'b0;
          ram_cs_n   <= 1'b1;
          ram_be_n   <= '1;
          pins_drive <= 1'b0;
        end
        TURN: begin
          if (tcnt != 2'd0) begin
            tcnt <= tcnt - 2'd1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Directed self-checking bench for sram_async_ctrl; three instances cover W=1/T=1, W=0/T=2 and W=0/T=0.
module tb_sram_async_ctrl;

`ifdef SRAM_RDATA_REG_EN
  localparam int unsigned X = 1;
`else
  localparam int unsigned X = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        we = 1'b0;
  logic [17:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  be = '0;
  logic        reqa = 1'b0, reqb = 1'b0, reqc = 1'b0;

  logic        a_busy, a_rvalid, a_cs_n, a_oe_n, a_we_n, a_drive;
  logic [15:0] a_rdata, a_dout, a_din;
  logic [17:0] a_adr;
  logic [1:0]  a_be_n;
  logic        b_busy, b_rvalid, b_cs_n, b_oe_n, b_we_n, b_drive;
  logic [15:0] b_rdata, b_dout, b_din;
  logic [17:0] b_adr;
  logic [1:0]  b_be_n;
  logic        c_busy, c_rvalid, c_cs_n, c_oe_n, c_we_n, c_drive;
  logic [15:0] c_rdata, c_dout, c_din;
  logic [17:0] c_adr;
  logic [1:0]  c_be_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // SRAM models only drive valid data while selected and output-enabled.
  assign a_din = (!a_cs_n && !a_oe_n) ? 16'hA55A : 16'hxxxx;
  assign b_din = (!b_cs_n && !b_oe_n) ? 16'h5AA5 : 16'hxxxx;
  assign c_din = (!c_cs_n && !c_oe_n) ? 16'h0F0F : 16'hxxxx;

  sram_async_ctrl #(.ADDR_W(18), .DATA_W(16), .WAIT_STATES(1), .TURNAROUND(1)) u_a (
    .clk(clk), .reset_n(reset_n), .req(reqa), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .busy(a_busy), .rdata(a_rdata), .rvalid(a_rvalid), .ram_adr(a_adr), .ram_cs_n(a_cs_n),
    .ram_oe_n(a_oe_n), .ram_we_n(a_we_n), .ram_be_n(a_be_n), .pins_dout(a_dout),
    .pins_din(a_din), .pins_drive(a_drive));

  sram_async_ctrl #(.ADDR_W(18), .DATA_W(16), .WAIT_STATES(0), .TURNAROUND(2)) u_b (
    .clk(clk), .reset_n(reset_n), .req(reqb), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .busy(b_busy), .rdata(b_rdata), .rvalid(b_rvalid), .ram_adr(b_adr), .ram_cs_n(b_cs_n),
    .ram_oe_n(b_oe_n), .ram_we_n(b_we_n), .ram_be_n(b_be_n), .pins_dout(b_dout),
    .pins_din(b_din), .pins_drive(b_drive));

  sram_async_ctrl #(.ADDR_W(18), .DATA_W(16), .WAIT_STATES(0), .TURNAROUND(0)) u_c (
    .clk(clk), .reset_n(reset_n), .req(reqc), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .busy(c_busy), .rdata(c_rdata), .rvalid(c_rvalid), .ram_adr(c_adr), .ram_cs_n(c_cs_n),
    .ram_oe_n(c_oe_n), .ram_we_n(c_we_n), .ram_be_n(c_be_n), .pins_dout(c_dout),
    .pins_din(c_din), .pins_drive(c_drive));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int unsigned accepts, r_at, d_at;
  logic        prev_busy, prev_oe_n;

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_strobes", {29'd0, a_cs_n, a_oe_n, a_we_n}, 32'h7);
    chk("rst_be_n", 32'(a_be_n), 32'h3);
    chk("rst_drive", 32'(a_drive), 32'd0);
    chk("rst_rdata", 32'(a_rdata), 32'd0);
    chk("rst_adr", 32'(a_adr), 32'd0);
    reset_n = 1'b1;
    step();

    // Write on A, W=1: addr/wdata changes after accept must be ignored
    we = 1'b1; addr = 18'h12345; wdata = 16'hBEEF; be = 2'b01; reqa = 1'b1;
    step();
    reqa = 1'b0; addr = 18'h00000; wdata = 16'h0000; be = 2'b10;
    for (int unsigned k = 1; k <= 6; k++) begin
      chk($sformatf("wr_busy_k%0d", k), 32'(a_busy), 32'(k <= 4));
      chk($sformatf("wr_we_n_k%0d", k), 32'(a_we_n), 32'(!(k >= 2 && k <= 3)));
      chk($sformatf("wr_drive_k%0d", k), 32'(a_drive), 32'(k <= 4));
      chk($sformatf("wr_oe_n_k%0d", k), 32'(a_oe_n), 32'd1);
      if (k <= 4) begin
        chk($sformatf("wr_be_n_k%0d", k), 32'(a_be_n), 32'h2);
        chk($sformatf("wr_dout_k%0d", k), 32'(a_dout), 32'hBEEF);
        chk($sformatf("wr_cs_n_k%0d", k), 32'(a_cs_n), 32'd0);
      end
      step();
    end
    chk("idle_adr_hold", 32'(a_adr), 32'h12345);
    chk("idle_dout_hold", 32'(a_dout), 32'hBEEF);

    // Read on A, W=1 T=1
    we = 1'b0; addr = 18'h00ABC; reqa = 1'b1;
    step();
    reqa = 1'b0;
    for (int unsigned k = 1; k <= 7; k++) begin
      chk($sformatf("rd_busy_k%0d", k), 32'(a_busy), 32'(k <= 4 + X));
      chk($sformatf("rd_rvalid_k%0d", k), 32'(a_rvalid), 32'(k == 4 + X));
      chk($sformatf("rd_drive_k%0d", k), 32'(a_drive), 32'd0);
      chk($sformatf("rd_oe_n_k%0d", k), 32'(a_oe_n), 32'(!(k <= 3 + X)));
      if (k <= 3 + X) chk($sformatf("rd_be_n_k%0d", k), 32'(a_be_n), 32'h0);
      if (k == 1) chk("rd_adr", 32'(a_adr), 32'h00ABC);
      if (k == 4 + X) chk("rd_rdata", 32'(a_rdata), 32'hA55A);
      step();
    end
    chk("rd_rdata_hold", 32'(a_rdata), 32'hA55A);

    // Read then write on B with req held, W=0 T=2
    we = 1'b0; addr = 18'h00042; reqb = 1'b1;
    accepts = 0; r_at = 0; d_at = 0;
    prev_busy = b_busy; prev_oe_n = b_oe_n;
    for (int unsigned k = 1; k <= 25; k++) begin
      step();
      if (b_busy && !prev_busy) begin
        accepts++;
        if (accepts == 1) begin
          we = 1'b1; wdata = 16'h1234; be = 2'b11;
        end else begin
          reqb = 1'b0;
        end
      end
      if (!prev_oe_n && b_oe_n && r_at == 0) r_at = k;
      if (b_drive && d_at == 0) d_at = k;
      if (b_drive && !b_oe_n) chk("rw_drive_oe_overlap", 32'd1, 32'd0);
      if (b_rvalid) chk("rw_rdata", 32'(b_rdata), 32'h5AA5);
      prev_busy = b_busy; prev_oe_n = b_oe_n;
    end
    chk("rw_accepts", 32'(accepts), 32'd2);
    chk("rw_oe_seen", 32'(r_at != 0), 32'd1);
    chk("rw_turn_gap", 32'(d_at - r_at), 32'd3);
    chk("rw_dout", 32'(b_dout), 32'h1234);

    // Read on C, W=0 T=0
    we = 1'b0; addr = 18'h3FFFF; reqc = 1'b1;
    step();
    reqc = 1'b0;
    for (int unsigned k = 1; k <= 5; k++) begin
      chk($sformatf("c_rvalid_k%0d", k), 32'(c_rvalid), 32'(k == 3 + X));
      chk($sformatf("c_busy_k%0d", k), 32'(c_busy), 32'(k <= 2 + X));
      if (k == 3 + X) chk("c_rdata", 32'(c_rdata), 32'h0F0F);
      step();
    end
    chk("c_adr", 32'(c_adr), 32'h3FFFF);

    // Asynchronous reset during write ACCESS on A
    we = 1'b1; addr = 18'h00777; wdata = 16'hCAFE; be = 2'b10; reqa = 1'b1;
    step();
    reqa = 1'b0;
    step();
    chk("ar_we_n_low", 32'(a_we_n), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_we_n", 32'(a_we_n), 32'd1);
    chk("ar_cs_n", 32'(a_cs_n), 32'd1);
    chk("ar_drive", 32'(a_drive), 32'd0);
    chk("ar_busy", 32'(a_busy), 32'd0);
    chk("ar_dout", 32'(a_dout), 32'd0);
    chk("ar_adr", 32'(a_adr), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("ar_idle_busy", 32'(a_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
